// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, default device address, ACK levels
// and a small majority-vote helper for the optional input glitch filter.
package i2c_pkg;

  localparam logic [6:0] DEFAULT_TEMP_ADDR = 7'h48;
  localparam logic       I2C_ACK           = 1'b0;
  localparam logic       I2C_NACK          = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX_BYTE,
    ST_TX_MACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_IGNORE
  } i2c_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_temp_responder_if.sv
// I2C pin bundle seen by the temperature responder. The bus side (master
// modport) supplies SCL/SDA levels; the target (slave modport) returns the
// open-drain SDA pull-down enable. SCL is never driven by the target.
interface i2c_temp_responder_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_bus_monitor.sv
// Oversampling I2C bus monitor: 2-FF synchronizers, edge history and
// SCL edge / START / STOP pulses. Optional filter: I2C_GLITCH_FILTER_EN.
module i2c_bus_monitor
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_lvl,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // Everything resets to the idle-bus level so reset release never fakes an edge.
  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_hist_q, scl_hist_d;
  logic       sda_hist_q, sda_hist_d;

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_win_q, scl_win_d;
  logic [2:0] sda_win_q, sda_win_d;

  always_comb begin
    scl_win_d = {scl_win_q[1:0], scl_sync_q[1]};
    sda_win_d = {sda_win_q[1:0], sda_sync_q[1]};
    scl_lvl   = maj3(scl_win_q);
    sda_lvl   = maj3(sda_win_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_win_q <= 3'b111;
      sda_win_q <= 3'b111;
    end else begin
      scl_win_q <= scl_win_d;
      sda_win_q <= sda_win_d;
    end
  end
`else
  always_comb begin
    scl_lvl = scl_sync_q[1];
    sda_lvl = sda_sync_q[1];
  end
`endif

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_hist_d = scl_lvl;
    sda_hist_d = sda_lvl;
    scl_rise   = scl_lvl & ~scl_hist_q;
    scl_fall   = ~scl_lvl & scl_hist_q;
    start_det  = scl_lvl & scl_hist_q & sda_hist_q & ~sda_lvl;
    stop_det   = scl_lvl & scl_hist_q & ~sda_hist_q & sda_lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target emulating a temperature sensor: ACKs DEV_ADDR, returns a coherent
// 16-bit snapshot on reads, ACKs and discards writes. Filter macro: I2C_GLITCH_FILTER_EN.
module i2c_temp_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_TEMP_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  i2c_temp_responder_if.slave  bus,
  input  logic [15:0]          temp_data,
  output logic                 busy,
  output logic                 rd_done,
  output i2c_state_e           state_dbg
);

  logic scl_lvl, sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .rst_n     (reset),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_lvl   (scl_lvl),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] snap_q, snap_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        ack_ph_q, ack_ph_d;
  logic        byte_lo_q, byte_lo_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        rd_done_q, rd_done_d;
  logic [7:0]  in_byte;

  always_comb begin
    in_byte   = {shift_q[6:0], sda_lvl};
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    snap_d    = snap_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    ack_ph_d  = ack_ph_q;
    byte_lo_d = byte_lo_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rd_done_d = 1'b0;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = in_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (in_byte[7:1] == DEV_ADDR) begin
              state_d  = ST_ADDR_ACK;
              busy_d   = 1'b1;
              rw_d     = in_byte[0];
              ack_ph_d = 1'b0;
              // Snapshot on the match clock so both bytes come from one sample.
              if (in_byte[0]) snap_d = temp_data;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK, ST_RX_ACK: if (scl_fall) begin
          if (!ack_ph_q) begin
            sda_oe_d = 1'b1;
            ack_ph_d = 1'b1;
          end else begin
            ack_ph_d = 1'b0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              // First data bit goes out on the same edge that ends the ACK.
              state_d   = ST_TX_BYTE;
              sda_oe_d  = ~snap_q[15];
              tx_d      = {snap_q[14:8], 1'b0};
              cnt_d     = 4'd1;
              byte_lo_d = 1'b0;
            end else begin
              state_d  = ST_RX_BYTE;
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
            end
          end
        end
        ST_TX_BYTE: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            state_d  = ST_TX_MACK;
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
            cnt_d    = cnt_q + 4'd1;
          end
        end
        ST_TX_MACK: if (scl_rise) begin
          rd_done_d = byte_lo_q;
          if (sda_lvl == I2C_ACK) begin
            state_d   = ST_TX_BYTE;
            cnt_d     = 4'd0;
            byte_lo_d = ~byte_lo_q;
            tx_d      = byte_lo_q ? snap_q[15:8] : snap_q[7:0];
          end else begin
            state_d = ST_IGNORE;
            busy_d  = 1'b0;
          end
        end
        ST_RX_BYTE: if (scl_rise) begin
          shift_d = in_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d    = 4'd0;
            state_d  = ST_RX_ACK;
            ack_ph_d = 1'b0;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 8'd0;
      snap_q    <= 16'd0;
      tx_q      <= 8'd0;
      rw_q      <= 1'b0;
      ack_ph_q  <= 1'b0;
      byte_lo_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      snap_q    <= snap_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      ack_ph_q  <= ack_ph_d;
      byte_lo_q <= byte_lo_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rd_done_q <= rd_done_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign busy       = busy_q;
  assign rd_done    = rd_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Directed bench for i2c_temp_responder: a bit-banged I2C master with SCL at
// 1/16 of clk, wired-AND SDA, and immediate-assertion checks.
module tb_i2c_temp_responder;
  import i2c_pkg::*;

  logic        clk;
  logic        reset;
  logic        m_scl;
  logic        m_sda;
  logic [15:0] temp_data;
  logic        busy;
  logic        rd_done;
  i2c_state_e  state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int rd_cnt    = 0;
  int oe_cnt    = 0;

  i2c_temp_responder_if bus ();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  i2c_temp_responder #(.DEV_ADDR(7'h48)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .temp_data (temp_data),
    .busy      (busy),
    .rd_done   (rd_done),
    .state_dbg (state_dbg)
  );

  // Clock / event monitors
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_done) rd_cnt <= rd_cnt + 1;
    if (bus.sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Master driver tasks
  task automatic i2c_start();
    m_sda = 1'b1; tick(4);
    m_scl = 1'b1; tick(4);
    m_sda = 1'b0; tick(4);
    m_scl = 1'b0; tick(4);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(4);
    m_scl = 1'b1; tick(4);
    m_sda = 1'b1; tick(4);
  endtask

  task automatic bit_xfer(input logic b, output logic line);
    m_sda = b;    tick(4);
    m_scl = 1'b1; tick(4);
    line  = bus.sda_in;
    tick(4);
    m_scl = 1'b0; tick(4);
  endtask

  task automatic write_byte(input logic [7:0] data, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) bit_xfer(data[i], l);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] data, input logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, l);
      data[i] = l;
    end
    bit_xfer(ack, l);
  endtask

  initial begin
    logic       ack;
    logic       l;
    logic [7:0] b;
    int         rd_base;
    int         oe_base;

    reset     = 1'b0;
    m_scl     = 1'b1;
    m_sda     = 1'b1;
    temp_data = 16'h1A40;
    tick(3);
    check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_done", 32'(rd_done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b1;
    tick(5);

    // Plain read: ACK high byte, NACK low byte
    rd_base = rd_cnt;
    i2c_start();
    write_byte(8'h91, ack);
    check("rd_addr_ack", 32'(ack), 32'(I2C_ACK));
    check("rd_busy", 32'(busy), 32'd1);
    read_byte(b, I2C_ACK);
    check("rd_hi", 32'(b), 32'h1A);
    read_byte(b, I2C_NACK);
    check("rd_lo", 32'(b), 32'h40);
    check("rd_done_cnt", 32'(rd_cnt - rd_base), 32'd1);
    check("rd_busy_nack", 32'(busy), 32'd0);
    i2c_stop();
    tick(4);
    check("rd_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Address mismatch: target must never pull SDA
    oe_base = oe_cnt;
    i2c_start();
    write_byte(8'h93, ack);
    check("mis_addr_nack", 32'(ack), 32'(I2C_NACK));
    write_byte(8'h55, ack);
    check("mis_data_nack", 32'(ack), 32'(I2C_NACK));
    check("mis_busy", 32'(busy), 32'd0);
    check("mis_no_oe", 32'(oe_cnt - oe_base), 32'd0);
    i2c_stop();
    tick(4);
    check("mis_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Snapshot coherence and wrap back to the high byte
    temp_data = 16'h1A40;
    rd_base   = rd_cnt;
    i2c_start();
    write_byte(8'h91, ack);
    read_byte(b, I2C_ACK);
    check("snap_b0", 32'(b), 32'h1A);
    temp_data = 16'h2B51;
    read_byte(b, I2C_ACK);
    check("snap_b1", 32'(b), 32'h40);
    read_byte(b, I2C_NACK);
    check("snap_wrap", 32'(b), 32'h1A);
    check("snap_rd_done", 32'(rd_cnt - rd_base), 32'd1);
    i2c_stop();
    tick(4);

    // Write: every byte ACKed, busy drops one clk after STOP is recognised
    i2c_start();
    write_byte(8'h90, ack);
    check("wr_addr_ack", 32'(ack), 32'(I2C_ACK));
    write_byte(8'h01, ack);
    check("wr_b0_ack", 32'(ack), 32'(I2C_ACK));
    write_byte(8'h60, ack);
    check("wr_b1_ack", 32'(ack), 32'(I2C_ACK));
    m_sda = 1'b0; tick(4);
    m_scl = 1'b1; tick(4);
    m_sda = 1'b1;
    tick(2);
    check("wr_busy_hold", 32'(busy), 32'd1);
    tick(1);
    check("wr_busy_drop", 32'(busy), 32'd0);
    tick(4);

    // Repeated START in the middle of a TX byte
    temp_data = 16'h1A40;
    i2c_start();
    write_byte(8'h91, ack);
    read_byte(b, I2C_ACK);
    bit_xfer(1'b1, l);
    check("rs_bit7", 32'(l), 32'd0);
    temp_data = 16'h2B51;
    m_sda = 1'b1; tick(4);
    m_scl = 1'b1; tick(4);
    m_sda = 1'b0; tick(4);
    check("rs_state", 32'(state_dbg), 32'(ST_ADDR));
    check("rs_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    m_scl = 1'b0; tick(4);
    write_byte(8'h91, ack);
    check("rs_addr_ack", 32'(ack), 32'(I2C_ACK));
    read_byte(b, I2C_ACK);
    check("rs_hi", 32'(b), 32'h2B);
    read_byte(b, I2C_NACK);
    check("rs_lo", 32'(b), 32'h51);
    i2c_stop();
    tick(4);

    // Asynchronous reset while the target is pulling SDA
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(1'(8'h91 >> i), l);
    m_sda = 1'b1;
    tick(4);
    check("ar_oe_before", 32'(bus.sda_oe), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("ar_oe_async", 32'(bus.sda_oe), 32'd0);
    check("ar_busy_async", 32'(busy), 32'd0);
    check("ar_state_async", 32'(state_dbg), 32'(ST_IDLE));
    tick(2);
    reset = 1'b1;
    tick(2);
    write_byte(8'h91, ack);
    check("ar_no_ack", 32'(ack), 32'(I2C_NACK));
    check("ar_idle", 32'(state_dbg), 32'(ST_IDLE));
    i2c_stop();
    tick(4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
